// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// Package : lsu_pkg
// Brief   : Shared funct3 encodings, FSM states and defaults for the LSU.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned MEM_WORDS_DEFAULT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RMW_READ = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_t;

  // Stores only have B/H/W; loads additionally have BU/HU.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 > F3_W);
    end
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// Interface : load_store_unit_if
// Brief     : Core request/response and data-memory signals of the LSU.
// Rev       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        rsp_fault;

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  // Environment side: drives requests and returns memory read data.
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault,
    input  mem_address, mem_read, mem_write, mem_write_data
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault,
    output mem_address, mem_read, mem_write, mem_write_data
  );

endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// Module : lsu_align
// Brief  : Byte/half lane extraction with extension, store merge, alignment check.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o,
  output logic        misaligned_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word_i[{offset_i, 3'b000} +: 8];
    w_half = offset_i[1] ? word_i[31:16] : word_i[15:0];

    load_data_o = word_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{w_byte[7]}}, w_byte};
      F3_BU:   load_data_o = {24'h000000, w_byte};
      F3_H:    load_data_o = {{16{w_half[15]}}, w_half};
      F3_HU:   load_data_o = {16'h0000, w_half};
      default: load_data_o = word_i;
    endcase

    merged_o = word_i;
    case (funct3_i[1:0])
      2'b00:   merged_o[{offset_i, 3'b000} +: 8]   = store_data_i[7:0];
      2'b01:   merged_o[{offset_i[1], 4'b0000} +: 16] = store_data_i[15:0];
      default: merged_o = store_data_i;
    endcase

    // funct3[1:0] carries the access size for both signed and unsigned forms.
    case (funct3_i[1:0])
      2'b01:   misaligned_o = offset_i[0];
      2'b10:   misaligned_o = (offset_i != 2'b00);
      default: misaligned_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// Module : load_store_unit
// Brief  : RV32I load/store sequencer onto a word-addressed memory (RMW for SB/SH).
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus_io
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misaligned_q, misaligned_d;
  logic        fault_q, fault_d;

  logic [1:0]  w_offset;
  logic [2:0]  w_funct3;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;
  logic        w_misaligned;
  logic        w_illegal;
  logic        w_range;

  // The aligner checks the incoming request in IDLE and the captured one afterwards.
  assign w_offset  = (state_q == ST_IDLE) ? bus_io.req_addr[1:0] : addr_q[1:0];
  assign w_funct3  = (state_q == ST_IDLE) ? bus_io.req_funct3    : funct3_q;
  assign w_illegal = f3_illegal(bus_io.req_write, bus_io.req_funct3);
  assign w_range   = ({2'b00, bus_io.req_addr[31:2]} >= MEM_WORDS);

  lsu_align u_align (
    .word_i       (bus_io.mem_read_data),
    .offset_i     (w_offset),
    .funct3_i     (w_funct3),
    .store_data_i (wdata_q),
    .load_data_o  (w_load_data),
    .merged_o     (w_merged),
    .misaligned_o (w_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= 32'h0;
      funct3_q     <= 3'b000;
      write_q      <= 1'b0;
      wdata_q      <= 32'h0;
      merged_q     <= 32'h0;
      rdata_q      <= 32'h0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      funct3_q     <= funct3_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      merged_q     <= merged_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    merged_d     = merged_q;
    rdata_d      = rdata_q;
    misaligned_d = misaligned_q;
    fault_d      = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (bus_io.req_valid) begin
          addr_d       = bus_io.req_addr;
          funct3_d     = bus_io.req_funct3;
          write_d      = bus_io.req_write;
          wdata_d      = bus_io.req_wdata;
          rdata_d      = 32'h0;
          // Priority: illegal funct3, then misalignment, then range.
          misaligned_d = !w_illegal && w_misaligned;
          fault_d      = w_illegal || (!w_misaligned && w_range);
          if (w_illegal || w_misaligned || w_range) begin
            state_d = ST_RESP;
          end else if (!bus_io.req_write) begin
            state_d = ST_LOAD;
          end else if (bus_io.req_funct3 == F3_W) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RMW_READ;
          end
        end
      end
      ST_LOAD: begin
        rdata_d = w_load_data;
        state_d = ST_RESP;
      end
      ST_RMW_READ: begin
        merged_d = w_merged;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes decode straight from state so an async reset kills them immediately.
  assign bus_io.req_ready      = (state_q == ST_IDLE);
  assign bus_io.rsp_valid      = (state_q == ST_RESP);
  assign bus_io.rsp_rdata      = rdata_q;
  assign bus_io.rsp_misaligned = misaligned_q;
  assign bus_io.rsp_fault      = fault_q;
  assign bus_io.mem_address    = {addr_q[31:2], 2'b00};
  assign bus_io.mem_read       = (state_q == ST_LOAD) || (state_q == ST_RMW_READ);
  assign bus_io.mem_write      = (state_q == ST_WRITE) && write_q;
  assign bus_io.mem_write_data = (funct3_q == F3_W) ? wdata_q : merged_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// Module : tb_load_store_unit
// Brief  : Directed self-checking bench for load_store_unit with a word memory model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  logic [31:0] mem [0:1023];
  logic        poke_en;
  logic [9:0]  poke_idx;
  logic [31:0] poke_val;

  assign bus.mem_read_data = mem[bus.mem_address[11:2]];

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (bus.mem_write) mem[bus.mem_address[11:2]] <= bus.mem_write_data;
  end

  int rd_seen = 0;
  int wr_seen = 0;
  int both_seen = 0;
  always @(negedge clk) begin
    if (bus.mem_read) rd_seen <= rd_seen + 1;
    if (bus.mem_write) wr_seen <= wr_seen + 1;
    if (bus.mem_read && bus.mem_write) both_seen <= both_seen + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic poke(input logic [9:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // Drive one request and wait (bounded) for the response strobe.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd,
                       output logic mis, output logic flt, output int nrd, output int nwr);
    int rd0, wr0;
    @(negedge clk);
    rd0 = rd_seen; wr0 = wr_seen;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      @(posedge clk);
      lat++;
    end
    rd = bus.rsp_rdata; mis = bus.rsp_misaligned; flt = bus.rsp_fault;
    nrd = rd_seen - rd0; nwr = wr_seen - wr0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b exp 0", bus.mem_read); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b exp 0", bus.mem_write); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.rsp_rdata); end
    checks++; if ({bus.rsp_misaligned, bus.rsp_fault} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {bus.rsp_misaligned, bus.rsp_fault}); end
  endtask

  task automatic test_loads();
    logic [31:0] a [6] = '{32'h16, 32'h16, 32'h16, 32'h14, 32'h14, 32'h15};
    logic [2:0]  f [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] e [6] = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_8081,
                           32'h0000_7F01, 32'h8081_7F01, 32'h0000_007F};
    int lat, nrd, nwr; logic [31:0] rd; logic mis, flt;
    poke(10'd5, 32'h8081_7F01);
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, f[i], a[i], 32'h0, lat, rd, mis, flt, nrd, nwr);
      checks++; if (rd !== e[i]) begin errors++; $display("FAIL load%0d_rdata got %h exp %h", i, rd, e[i]); end
      checks++; if ({lat, mis, flt, nrd, nwr} !== {32'd2, 2'b00, 32'd1, 32'd0}) begin
        errors++; $display("FAIL load%0d_ctl got lat=%0d mis=%b flt=%b rd=%0d wr=%0d exp 2 0 0 1 0", i, lat, mis, flt, nrd, nwr);
      end
    end
  endtask

  task automatic test_sub_word_store();
    int lat, nrd, nwr; logic [31:0] rd; logic mis, flt;
    issue(1'b1, 3'b000, 32'h15, 32'h1234_56AA, lat, rd, mis, flt, nrd, nwr);
    checks++; if (mem[5] !== 32'h8081_AA01) begin errors++; $display("FAIL sb_word got %h exp 8081aa01", mem[5]); end
    checks++; if ({lat, nrd, nwr} !== {32'd3, 32'd1, 32'd1}) begin errors++; $display("FAIL sb_ctl got lat=%0d rd=%0d wr=%0d exp 3 1 1", lat, nrd, nwr); end
    checks++; if ({rd, mis, flt} !== 34'h0) begin errors++; $display("FAIL sb_rsp got %h %b %b exp 0 0 0", rd, mis, flt); end
    issue(1'b1, 3'b001, 32'h16, 32'h0000_BEEF, lat, rd, mis, flt, nrd, nwr);
    checks++; if (mem[5] !== 32'hBEEF_AA01) begin errors++; $display("FAIL sh_word got %h exp beefaa01", mem[5]); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL sh_latency got %0d exp 3", lat); end
  endtask

  task automatic test_errors();
    logic        w [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f [6] = '{3'b001, 3'b010, 3'b011, 3'b011, 3'b001, 3'b010};
    logic [31:0] a [6] = '{32'h13, 32'h1000, 32'h14, 32'h13, 32'h1001, 32'hFFC};
    logic [1:0]  e [6] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
    int          el [6] = '{1, 1, 1, 1, 1, 2};
    int lat, nrd, nwr; logic [31:0] rd; logic mis, flt;
    poke(10'd1023, 32'hCAFE_0123);
    for (int i = 0; i < 6; i++) begin
      issue(w[i], f[i], a[i], 32'hFFFF_FFFF, lat, rd, mis, flt, nrd, nwr);
      checks++; if ({mis, flt} !== e[i]) begin errors++; $display("FAIL err%0d_flags got mis=%b flt=%b exp %b", i, mis, flt, e[i]); end
      checks++; if (lat !== el[i]) begin errors++; $display("FAIL err%0d_latency got %0d exp %0d", i, lat, el[i]); end
      if (i < 5) begin
        checks++; if ({nrd, nwr, rd} !== 96'h0) begin errors++; $display("FAIL err%0d_quiet got rd=%0d wr=%0d rdata=%h exp 0 0 0", i, nrd, nwr, rd); end
      end else begin
        checks++; if (rd !== 32'hCAFE_0123) begin errors++; $display("FAIL last_word_rdata got %h exp cafe0123", rd); end
      end
    end
  endtask

  task automatic test_reset_during_write();
    poke(10'd8, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h20; bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    checks++; if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL sw_in_write got %b exp 1", bus.mem_write); end
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_drop_write got %b exp 0", bus.mem_write); end
    checks++; if ({bus.rsp_valid, bus.mem_read, bus.rsp_misaligned, bus.rsp_fault, bus.rsp_rdata} !== 36'h0) begin
      errors++; $display("FAIL rst_outputs got v=%b r=%b m=%b f=%b d=%h exp all 0", bus.rsp_valid, bus.mem_read, bus.rsp_misaligned, bus.rsp_fault, bus.rsp_rdata);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", bus.req_ready); end
    checks++; if (mem[8] !== 32'h0) begin errors++; $display("FAIL rst_word8 got %h exp 0", mem[8]); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h20; bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.req_write = 1'b0; bus.req_wdata = 32'h0;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready got %b exp 0", bus.req_ready); end
    @(posedge clk); #1;
    checks++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL b2b_sw_rsp got v=%b d=%h exp 1 0", bus.rsp_valid, bus.rsp_rdata); end
    @(posedge clk); #1;
    checks++; if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin errors++; $display("FAIL b2b_idle got rdy=%b v=%b exp 1 0", bus.req_ready, bus.rsp_valid); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++; if ({bus.req_ready, bus.mem_read} !== 2'b01) begin errors++; $display("FAIL b2b_lw_accept got rdy=%b rd=%b exp 0 1", bus.req_ready, bus.mem_read); end
    @(posedge clk); #1;
    checks++; if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL b2b_lw_rsp got v=%b d=%h exp 1 deadbeef", bus.rsp_valid, bus.rsp_rdata); end
    checks++; if (mem[8] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_word8 got %h exp deadbeef", mem[8]); end
  endtask

  task automatic test_exclusive();
    checks++; if (both_seen !== 0) begin errors++; $display("FAIL rd_wr_overlap got %0d exp 0", both_seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    poke_en = 1'b0; poke_idx = '0; poke_val = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    test_reset();
    test_loads();
    test_sub_word_store();
    test_errors();
    test_reset_during_write();
    test_back_to_back();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
